// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the CNN datapath blocks.
// Contents: FP16 field widths, the all-ones exponent constant, the lane
// state enum used by the stream demux, and an is_nan helper.
package fp16_pkg;

  localparam int unsigned FP16_W = 16;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned MAN_W  = 10;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  typedef enum logic {
    LANE1 = 1'b0,
    LANE2 = 1'b1
  } lane_e;

  // NaN: exponent all ones with a non-zero mantissa (infinity has mantissa 0).
  function automatic logic is_nan(input logic [FP16_W-1:0] w);
    return (w[MAN_W +: EXP_W] == EXP_ALL_ONES) && (w[MAN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp16_lane_reg.sv
// One-entry valid/ready holding register for a single FP16 output lane.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load_i     - capture data_i this cycle (upstream transfer into this lane)
//   data_i     - word to capture
//   ready_i    - downstream consumer takes the held word
//   valid_o    - register holds a word
//   data_o     - held word (keeps its last value while empty)
module fp16_lane_reg
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [FP16_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [FP16_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [FP16_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    // A refill in the same cycle as a drain wins, keeping one word per cycle.
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fp16_stream_demux.sv
// Registered 1-to-2 demultiplexer for FP16 words. Groups of GROUP accepted
// words are steered alternately to out1 and out2, each lane buffering one word.
// Parameters:
//   GROUP      - words per lane before switching (1..255)
//   START_LANE - lane selected after reset (0 = out1, 1 = out2)
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   in_data, in_valid, in_ready       - input stream
//   out1_data, out1_valid, out1_ready - lane 1 output
//   out2_data, out2_valid, out2_ready - lane 2 output
//   lane                              - lane selected for the next input word
//   nan_seen                          - sticky NaN flag (only with FP16_DEMUX_NAN_EN)
// Build option: define FP16_DEMUX_NAN_EN to add the nan_seen port and logic.
module fp16_stream_demux
  import fp16_pkg::*;
#(
  parameter int unsigned GROUP      = 4,
  parameter int unsigned START_LANE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FP16_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FP16_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [FP16_W-1:0] out2_data,
  output logic              out2_valid,
  input  logic              out2_ready,
  output logic              lane
`ifdef FP16_DEMUX_NAN_EN
  ,
  output logic              nan_seen
`endif
);

  localparam logic [7:0] GroupLast = 8'(GROUP - 1);
  localparam lane_e      StartLane = (START_LANE != 0) ? LANE2 : LANE1;

  lane_e      state_q, state_d;
  logic [7:0] gcnt_q, gcnt_d;
  logic       in_xfer;
  logic       load1, load2;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StartLane;
      gcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Next state: count accepted words, switch lane after the last one of a group.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    if (in_xfer) begin
      if (gcnt_q == GroupLast) begin
        gcnt_d  = 8'd0;
        state_d = (state_q == LANE1) ? LANE2 : LANE1;
      end else begin
        gcnt_d = gcnt_q + 8'd1;
      end
    end
  end

  // Outputs: only the selected lane gates in_ready; the other lane drains on its own.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      LANE1:   in_ready = !out1_valid || out1_ready;
      LANE2:   in_ready = !out2_valid || out2_ready;
      default: in_ready = 1'b0;
    endcase
    in_xfer = in_valid && in_ready;
    load1   = in_xfer && (state_q == LANE1);
    load2   = in_xfer && (state_q == LANE2);
    lane    = (state_q == LANE2);
  end

  fp16_lane_reg u_lane1 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load1),
    .data_i  (in_data),
    .ready_i (out1_ready),
    .valid_o (out1_valid),
    .data_o  (out1_data)
  );

  fp16_lane_reg u_lane2 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load2),
    .data_i  (in_data),
    .ready_i (out2_ready),
    .valid_o (out2_valid),
    .data_o  (out2_data)
  );

`ifdef FP16_DEMUX_NAN_EN
  logic nan_seen_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_seen_q <= 1'b0;
    end else if (in_xfer && is_nan(in_data)) begin
      nan_seen_q <= 1'b1;
    end
  end

  assign nan_seen = nan_seen_q;
`endif

endmodule

// File: tb/tb_fp16_stream_demux.sv
// Scoreboard bench for fp16_stream_demux: the driver pushes each accepted word
// into the queue of the lane it must reach; a negedge monitor pops and compares
// whenever a lane hands a word to its consumer.
module tb_fp16_stream_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t0;

  // DUT A: GROUP=4, START_LANE=0
  logic [15:0] a_in_data;
  logic        a_in_valid, a_in_ready;
  logic [15:0] a_o1_data, a_o2_data;
  logic        a_o1_valid, a_o1_ready, a_o2_valid, a_o2_ready;
  logic        a_lane;
  // DUT B: GROUP=1, START_LANE=1
  logic [15:0] b_in_data;
  logic        b_in_valid, b_in_ready;
  logic [15:0] b_o1_data, b_o2_data;
  logic        b_o1_valid, b_o1_ready, b_o2_valid, b_o2_ready;
  logic        b_lane;
`ifdef FP16_DEMUX_NAN_EN
  logic        a_nan, b_nan;
`endif

  logic [15:0] qa1[$], qa2[$], qb1[$], qb2[$];
  bit          m_lane[2];
  int          m_cnt[2];
  int          grp[2] = '{4, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fp16_stream_demux #(.GROUP(4), .START_LANE(0)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_data    (a_in_data),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .out1_data  (a_o1_data),
    .out1_valid (a_o1_valid),
    .out1_ready (a_o1_ready),
    .out2_data  (a_o2_data),
    .out2_valid (a_o2_valid),
    .out2_ready (a_o2_ready),
    .lane       (a_lane)
`ifdef FP16_DEMUX_NAN_EN
    ,
    .nan_seen   (a_nan)
`endif
  );

  fp16_stream_demux #(.GROUP(1), .START_LANE(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_data    (b_in_data),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .out1_data  (b_o1_data),
    .out1_valid (b_o1_valid),
    .out1_ready (b_o1_ready),
    .out2_data  (b_o2_data),
    .out2_valid (b_o2_valid),
    .out2_ready (b_o2_ready),
    .lane       (b_lane)
`ifdef FP16_DEMUX_NAN_EN
    ,
    .nan_seen   (b_nan)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic extra(input string name, input logic [15:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected no word", name, act);
  endtask

  // Monitor: a handshake seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_o1_valid && a_o1_ready) begin
        if (qa1.size() == 0) extra("a_out1_extra", a_o1_data);
        else chk("a_out1_data", 32'(a_o1_data), 32'(qa1.pop_front()));
      end
      if (a_o2_valid && a_o2_ready) begin
        if (qa2.size() == 0) extra("a_out2_extra", a_o2_data);
        else chk("a_out2_data", 32'(a_o2_data), 32'(qa2.pop_front()));
      end
      if (b_o1_valid && b_o1_ready) begin
        if (qb1.size() == 0) extra("b_out1_extra", b_o1_data);
        else chk("b_out1_data", 32'(b_o1_data), 32'(qb1.pop_front()));
      end
      if (b_o2_valid && b_o2_ready) begin
        if (qb2.size() == 0) extra("b_out2_extra", b_o2_data);
        else chk("b_out2_data", 32'(b_o2_data), 32'(qb2.pop_front()));
      end
    end
  end

  task automatic flush();
    qa1.delete();
    qa2.delete();
    qb1.delete();
    qb2.delete();
    m_lane[0] = 1'b0;
    m_lane[1] = 1'b1;
    m_cnt[0]  = 0;
    m_cnt[1]  = 0;
  endtask

  // Drive one word into DUT A (b=0) or B (b=1); returns at posedge+1 after the transfer.
  task automatic send(input bit b, input logic [15:0] d);
    int   n;
    logic rdy;
    n = 0;
    if (b) begin b_in_data = d; b_in_valid = 1'b1; end
    else   begin a_in_data = d; a_in_valid = 1'b1; end
    @(negedge clk);
    rdy = b ? b_in_ready : a_in_ready;
    while (!rdy && n < 50) begin
      n++;
      @(negedge clk);
      rdy = b ? b_in_ready : a_in_ready;
    end
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles (word %h)", d);
    end else begin
      chk(b ? "b_lane" : "a_lane", 32'(b ? b_lane : a_lane), 32'(m_lane[b]));
      if (!b && !m_lane[b]) qa1.push_back(d);
      if (!b &&  m_lane[b]) qa2.push_back(d);
      if ( b && !m_lane[b]) qb1.push_back(d);
      if ( b &&  m_lane[b]) qb2.push_back(d);
      m_cnt[b]++;
      if (m_cnt[b] == grp[b]) begin
        m_cnt[b]  = 0;
        m_lane[b] = ~m_lane[b];
      end
    end
    @(posedge clk);
    #1;
    if (b) b_in_valid = 1'b0;
    else   a_in_valid = 1'b0;
  endtask

  initial begin
    a_in_data = '0; a_in_valid = 1'b0; a_o1_ready = 1'b1; a_o2_ready = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0; b_o1_ready = 1'b1; b_o2_ready = 1'b1;
    flush();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_o1_valid", 32'(a_o1_valid), 32'd0);
    chk("rst_o2_valid", 32'(a_o2_valid), 32'd0);
    chk("rst_o1_data", 32'(a_o1_data), 32'h0);
    chk("rst_o2_data", 32'(a_o2_data), 32'h0);
    chk("rst_lane_a", 32'(a_lane), 32'd0);
    chk("rst_gcnt_a", 32'(dut_a.gcnt_q), 32'd0);
    chk("rst_lane_b", 32'(b_lane), 32'd1);
    chk("rst_in_ready_b", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Stream 3C00..3C07, both consumers ready
    t0 = cyc;
    send(1'b0, 16'h3C00);
    chk("latency_o1_valid", 32'(a_o1_valid), 32'd1);
    chk("latency_o1_data", 32'(a_o1_data), 32'h3C00);
    for (int i = 1; i < 8; i++) send(1'b0, 16'h3C00 + 16'(i));
    chk("stream_cycles", 32'(cyc - t0), 32'd8);
    chk("stream_lane_back", 32'(a_lane), 32'd0);

    // Backpressure: leave 4C07 parked in out2, then fill out1 with a stalled consumer
    for (int i = 0; i < 8; i++) send(1'b0, 16'h4C00 + 16'(i));
    a_o2_ready = 1'b0;
    a_o1_ready = 1'b0;
    send(1'b0, 16'h4C08);
    a_in_data  = 16'h4C09;
    a_in_valid = 1'b1;
    a_o2_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      chk("bp_o1_hold", 32'(a_o1_data), 32'h4C08);
      chk("bp_gcnt_hold", 32'(dut_a.gcnt_q), 32'(m_cnt[0]));
    end
    chk("bp_o2_drained", 32'(a_o2_valid), 32'd0);
    @(posedge clk);
    #1;
    a_o1_ready = 1'b1;
    t0 = cyc;
    send(1'b0, 16'h4C09);
    send(1'b0, 16'h4C0A);
    send(1'b0, 16'h4C0B);
    chk("bp_refill_cycles", 32'(cyc - t0), 32'd3);
    chk("bp_lane_switched", 32'(a_lane), 32'd1);

    // Reset after 2 words of a lane-2 group, with a word still held in out2
    send(1'b0, 16'h5000);
    send(1'b0, 16'h5001);
    a_o2_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_o1_valid", 32'(a_o1_valid), 32'd0);
    chk("mid_rst_o2_valid", 32'(a_o2_valid), 32'd0);
    chk("mid_rst_lane", 32'(a_lane), 32'd0);
    chk("mid_rst_gcnt", 32'(dut_a.gcnt_q), 32'd0);
    flush();
    @(negedge clk);
    #1 rst = 1'b0;
    a_o2_ready = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 16'h5002);
    chk("post_rst_gcnt", 32'(dut_a.gcnt_q), 32'd1);

`ifdef FP16_DEMUX_NAN_EN
    chk("nan_init", 32'(a_nan), 32'd0);
    send(1'b0, 16'h7C00);
    chk("nan_inf_ignored", 32'(a_nan), 32'd0);
    send(1'b0, 16'h7E00);
    chk("nan_set", 32'(a_nan), 32'd1);
    send(1'b0, 16'h3C00);
    chk("nan_sticky", 32'(a_nan), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("nan_cleared", 32'(a_nan), 32'd0);
    flush();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
`endif

    // Alternation on DUT B: GROUP=1, START_LANE=1
    send(1'b1, 16'h0001);
    chk("alt_first_o2_valid", 32'(b_o2_valid), 32'd1);
    chk("alt_first_o2_data", 32'(b_o2_data), 32'h0001);
    send(1'b1, 16'h0002);
    chk("alt_second_o1_data", 32'(b_o1_data), 32'h0002);
    send(1'b1, 16'h0003);
    chk("alt_third_o2_data", 32'(b_o2_data), 32'h0003);

    repeat (4) @(posedge clk);
    #1;
    chk("qa1_empty", 32'(qa1.size()), 32'd0);
    chk("qa2_empty", 32'(qa2.size()), 32'd0);
    chk("qb1_empty", 32'(qb1.size()), 32'd0);
    chk("qb2_empty", 32'(qb2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp16_stream_demux.md
# fp16_stream_demux

Registered 1-to-2 demultiplexer for 16-bit half-precision words in the CNN datapath. It takes a single valid/ready stream of FP16 operands and steers fixed-size groups of words alternately to two output lanes, each holding one buffered word. It is the inverse of the select-driven 2:1 operand mux: that mux merges two operand sources onto one bus, and this block splits one bus back into two consumers. Lane switching comes from an internal group counter, not an external select clock.

## Interface
- `GROUP`, default 4: words sent to a lane before switching to the other lane; legal range 1..255.
- `START_LANE`, default 0: lane selected after reset; 0 = `out1`, 1 = `out2`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_data`, input, 16: FP16 word.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block accepts a word this cycle.
- `out1_data`, output, 16: lane 1 word.
- `out1_valid`, output, 1: lane 1 holds a word.
- `out1_ready`, input, 1: lane 1 consumer takes the word.
- `out2_data`, output, 16: lane 2 word.
- `out2_valid`, output, 1: lane 2 holds a word.
- `out2_ready`, input, 1: lane 2 consumer takes the word.
- `lane`, output, 1: lane currently selected for the next input (0 = `out1`).
- `nan_seen`, output, 1: sticky NaN flag. Present only with `FP16_DEMUX_NAN_EN`.

## Operation
- The FSM has two states: `LANE1` and `LANE2`. The group counter `gcnt` is 8 bits wide and counts 0..`GROUP`-1.
- Input transfer: a transfer happens when `in_valid && in_ready`. The word is loaded into the selected lane's register and that lane's valid is set.
- Ready rule: `in_ready = !selX_valid || selX_ready`, where selX is the selected lane's register.
  - A full lane that drains and refills in the same cycle sustains one word per cycle.
- Output transfer: a lane's valid clears when `outX_valid && outX_ready`, unless the lane is refilled in the same cycle.
- Counter: on each input transfer, `gcnt` increments. When `gcnt == GROUP-1`, `gcnt` wraps to 0 and the state toggles.
  - With `GROUP` = 1, the lane alternates on every word.
- No reordering: a stall on the selected lane blocks input, even when the other lane is empty. The lane does not switch early.
- Lanes drain independently. A draining non-selected lane never affects `in_ready`.
- Output data is held stable while valid is high and ready is low. Data is don't-care while valid is low, but the register holds its last value.
- Data passes bit-exact. No FP16 arithmetic is performed.
- Reset values: `out1_valid`, `out2_valid` = 0; `out1_data`, `out2_data` = 16'h0000; `gcnt` = 0; `lane` = `START_LANE`; `nan_seen` = 0.
  - `in_ready` = 1 directly after reset, because both lanes are empty.
- Reset mid-operation: buffered words are discarded and no partial group is remembered. Consumers see valid drop asynchronously.

## Timing
- Latency: a word accepted at edge N appears on `outX_data`/`outX_valid` after edge N. It is visible in cycle N+1.
- Throughput: 1 word/cycle when the selected consumer holds ready high.
- `in_ready` is combinational from the selected lane's valid and `outX_ready`. There is no path from `in_valid` to `in_ready`.
- `lane` is registered and changes on the edge of the group's last transfer.

## Configuration
- `FP16_DEMUX_NAN_EN` defined:
  - An accepted word with exponent 5'h1F and mantissa != 0 sets `nan_seen` on that edge.
  - `nan_seen` is cleared only by `rst`.
- `FP16_DEMUX_NAN_EN` undefined: the `nan_seen` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `fp16_pkg`:
  - FP16 field widths: `FP16_W` = 16, `EXP_W` = 5, `MAN_W` = 10.
  - `EXP_ALL_ONES` constant.
  - Lane state enum: `LANE1`, `LANE2`.
  - `is_nan` function, reused by other FP16 blocks.
- One sub-module, `fp16_lane_reg`: a one-entry valid/ready holding register, instantiated twice.
- Group counter and FSM live in the top module.

## Test plan
- Reset then stream: after `rst`, stream 16'h3C00..16'h3C07 with both readies high. Required routing: `out1` = 3C00–3C03, `out2` = 3C04–3C07, one per cycle, each one cycle after acceptance. `lane` returns to 0 after the last word.
- Backpressure: hold `out1_ready` = 0 with `out1` full and lane 1 selected. Required: `in_ready` = 0 while `out2` drains freely. Raise `out1_ready`: the refill and drain occur in the same cycle, and throughput is 1/cycle.
- Alternation: with `GROUP` = 1 and `START_LANE` = 1, send 16'h0001, 16'h0002, 16'h0003. Required: `out2` gets 0001 and 0003; `out1` gets 0002.
- Reset mid-group: assert `rst` asynchronously after 2 words of a 4-word group. Required: both valids = 0 immediately, `gcnt` = 0, `lane` = `START_LANE`. The next word goes to the start lane.
- NaN flag (`FP16_DEMUX_NAN_EN`): send 16'h7C00 (infinity). Required: `nan_seen` stays 0. Then send 16'h7E00. Required: `nan_seen` = 1 after that edge and stays 1 until `rst`.
- Valid without ready: hold `in_valid` = 1 with `in_ready` = 0 for 5 cycles. Required: no transfer, `gcnt` unchanged, and output data stays stable.
